// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks the enabled channels of a 4:1 mux in ascending order,
// holds each select for a programmable dwell, and captures one bit per channel.
// Optional feature macro: MUX_SCAN_CONT_EN (continuous re-scan via cont input).
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
`ifdef MUX_SCAN_CONT_EN
    input  logic               cont,
`endif
    input  logic               mux_out,
    output logic [1:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sample
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         sel_reg, sel_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [3:0]         mask_reg, mask_next;
    logic [3:0]         work_reg, work_next;
    logic [3:0]         sample_reg, sample_next;

    // Enabled channels strictly above the current select.
    logic [3:0] above_mask;
    logic       has_next;
    logic [1:0] next_sel;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] low_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (gi > int'(sel_reg));
        end
    endgenerate

    assign has_next = |above_mask;
    assign next_sel = low_bit(above_mask);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sel_reg    <= 2'd0;
            cnt_reg    <= '0;
            dwell_reg  <= '0;
            mask_reg   <= 4'd0;
            work_reg   <= 4'd0;
            sample_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            cnt_reg    <= cnt_next;
            dwell_reg  <= dwell_next;
            mask_reg   <= mask_next;
            work_reg   <= work_next;
            sample_reg <= sample_next;
        end
    end

    // Next-state logic: accept start, count dwell, capture, advance channel.
    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        cnt_next    = cnt_reg;
        dwell_next  = dwell_reg;
        mask_next   = mask_reg;
        work_next   = work_reg;
        sample_next = sample_reg;
        case (state_reg)
            IDLE: begin
                sel_next = 2'd0;
                if (start) begin
                    dwell_next = dwell;
                    mask_next  = ch_mask;
                    work_next  = 4'd0;
                    if (ch_mask != 4'd0) begin
                        sel_next   = low_bit(ch_mask);
                        cnt_next   = dwell;
                        state_next = DWELL;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DWELL: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end else begin
                    // The mux has settled for dwell_q cycles on this select.
                    work_next[sel_reg] = mux_out;
                    if (has_next) begin
                        sel_next = next_sel;
                        cnt_next = dwell_reg;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                sample_next = work_reg;
                sel_next    = 2'd0;
                state_next  = IDLE;
`ifdef MUX_SCAN_CONT_EN
                if (cont && (mask_reg != 4'd0)) begin
                    sel_next   = low_bit(mask_reg);
                    cnt_next   = dwell_reg;
                    work_next  = 4'd0;
                    state_next = DWELL;
                end
`endif
            end
            default: begin
                state_next = IDLE;
                sel_next   = 2'd0;
            end
        endcase
    end

    assign sel    = sel_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign sample = sample_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl with a behavioural 4:1 mux.
// Expected per-cycle sel/busy/done/sample tuples are queued when a scan starts.
module tb_mux_scan_ctrl;

    localparam int DWELL_W = 4;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [DWELL_W-1:0] dwell_in;
    logic [3:0]         ch_mask;
`ifdef MUX_SCAN_CONT_EN
    logic               cont;
`endif
    logic               mux_out;
    logic [1:0]         sel;
    logic               busy;
    logic               done;
    logic [3:0]         sample;
    logic [3:0]         in_c;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic [3:0] smp;
    } exp_t;

    exp_t       q[$];
    int         cyc;
    int         total;
    int         bad;
    bit         mon_en;
    logic [3:0] prev_smp;

    mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dwell   (dwell_in),
        .ch_mask (ch_mask),
`ifdef MUX_SCAN_CONT_EN
        .cont    (cont),
`endif
        .mux_out (mux_out),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .sample  (sample)
    );

    // Behavioural model of the downstream 4:1 mux.
    assign mux_out = in_c[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_t(input int c, input logic [1:0] s, input logic b, input logic d,
                          input logic [3:0] smp);
        exp_t t;
        t.cyc = c; t.sel = s; t.busy = b; t.done = d; t.smp = smp;
        q.push_back(t);
    endtask

    // Expected trace of one scan whose start is taken on edge e.
    task automatic push_scan(input int e, input logic [3:0] m, input int d, input logic [3:0] res);
        int         t;
        logic [1:0] last;
        t    = e;
        last = 2'd0;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k <= d; k++) begin
                    push_t(t, 2'(ch), 1'b1, 1'b0, prev_smp);
                    t++;
                end
                last = 2'(ch);
            end
        end
        push_t(t, last, 1'b1, 1'b1, prev_smp);
        t++;
        push_t(t, 2'd0, 1'b0, 1'b0, res);
        prev_smp = res;
    endtask

    // One scan request; optionally disturb start/ch_mask/dwell while busy.
    task automatic run_scan(input logic [3:0] m, input int d, input logic [3:0] inv, input bit disturb);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (m[i]) n++;
        @(negedge clk);
        in_c     = inv;
        ch_mask  = m;
        dwell_in = DWELL_W'(d);
        start    = 1'b1;
        push_scan(cyc + 1, m, d, inv & m);
        for (int i = 0; i < n * (d + 1) + 4; i++) begin
            @(negedge clk);
            start = disturb && (i == 0 || i == 2);
            if (disturb) begin
                ch_mask  = 4'b0001;
                dwell_in = '0;
            end
        end
    endtask

    // Scoreboard: compare queued expectations on their cycle, otherwise expect idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t t;
                t = q.pop_front();
                chk("sel", 32'(sel), 32'(t.sel));
                chk("busy", 32'(busy), 32'(t.busy));
                chk("done", 32'(done), 32'(t.done));
                chk("sample", 32'(sample), 32'(t.smp));
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_sel", 32'(sel), 32'd0);
            end
        end
    end

    initial begin
        cyc      = 0;
        total    = 0;
        bad      = 0;
        mon_en   = 1'b0;
        prev_smp = 4'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dwell_in = '0;
        ch_mask  = 4'd0;
        in_c     = 4'd0;
`ifdef MUX_SCAN_CONT_EN
        cont     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Full scan, one cycle per channel.
        run_scan(4'b1111, 0, 4'b1010, 1'b0);

        // Reset in the middle of a long scan aborts it and clears sample.
        mon_en = 1'b0;
        @(negedge clk);
        ch_mask  = 4'b1111;
        dwell_in = DWELL_W'(3);
        in_c     = 4'b0101;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_sample", 32'(sample), 32'd0);
        rst_n    = 1'b1;
        prev_smp = 4'd0;
        mon_en   = 1'b1;
        repeat (20) @(negedge clk);

        // Sparse mask with dwell, empty mask, ignored mid-scan inputs, max dwell.
        run_scan(4'b1010, 2, 4'b1111, 1'b0);
        run_scan(4'b0000, 5, 4'b1111, 1'b0);
        run_scan(4'b1100, 1, 4'b0110, 1'b1);
        run_scan(4'b1111, 15, 4'b0101, 1'b0);
        run_scan(4'b1001, 0, 4'b0110, 1'b0);

`ifdef MUX_SCAN_CONT_EN
        // Continuous mode: three back-to-back passes, in_c changing per pass.
        begin
            int         e;
            logic [3:0] v [3];
            v[0] = 4'b0001; v[1] = 4'b0010; v[2] = 4'b0011;
            @(negedge clk);
            in_c     = v[0];
            ch_mask  = 4'b0011;
            dwell_in = DWELL_W'(1);
            cont     = 1'b1;
            start    = 1'b1;
            e        = cyc + 1;
            for (int p = 0; p < 3; p++) begin
                for (int k = 0; k < 4; k++)
                    push_t(e + p * 5 + k, (k < 2) ? 2'd0 : 2'd1, 1'b1, 1'b0, prev_smp);
                push_t(e + p * 5 + 4, 2'd1, 1'b1, 1'b1, prev_smp);
                prev_smp = v[p] & 4'b0011;
            end
            push_t(e + 15, 2'd0, 1'b0, 1'b0, prev_smp);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (i == 4)  in_c = v[1];
                if (i == 9)  in_c = v[2];
                if (i == 10) cont = 1'b0;
            end
        end
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
